icache_dm: RTL and testbench
============================

// Module: icache_dm
// PURPOSE
//  Parametrised direct-mapped instruction cache between fetch stage and instruction memory.
//  Multi-word lines with tag and valid bits; refill FSM with valid/ready memory handshake.
//  Supports global flush. Replaces the flat write-port instruction store.
//  Fetch issues byte addresses and receives one instruction word per accepted request.
// PARAMETERS
//  ADDR_W      32  byte-address width
//  DATA_W      32  instruction word width; byte offset bits OFF_B = log2(DATA_W/8)
//  SETS        16  number of lines, power of 2; index bits IDX_B = log2(SETS)
//  LINE_WORDS   4  words per line, power of 2 >= 1; word-select bits WRD_B = log2(LINE_WORDS)
//  Address split: tag = [ADDR_W-1 : OFF_B+WRD_B+IDX_B] | index | word | byte offset (ignored)
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous active-high reset
//  cpu_req_valid  in   1       fetch request
//  cpu_req_addr   in   ADDR_W  fetch byte address; low OFF_B bits ignored
//  cpu_req_ready  out  1       request accepted when valid & ready at posedge
//  cpu_resp_valid out  1       response strobe, 1 cycle; no backpressure
//  cpu_resp_data  out  DATA_W  instruction word
//  flush          in   1       invalidate all lines
//  mem_req_valid  out  1       line refill request
//  mem_req_addr   out  ADDR_W  line-aligned byte address (word and offset bits zero)
//  mem_req_ready  in   1       memory accepts request
//  mem_resp_valid in   1       one refill beat, words in ascending order
//  mem_resp_data  in   DATA_W  refill beat data
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high. Ports are clk and rst.
//  Reset: all valid bits 0, FSM=IDLE, flush_pending=0, beat count 0.
//    Outputs during and after reset: cpu_resp_valid=0, cpu_resp_data=0, mem_req_valid=0, mem_req_addr=0.
//    Tag and data arrays are not reset.
//  cpu_req_ready = (state==IDLE) & !flush & !flush_pending.
//  IDLE, request accepted, hit (valid[idx] & tag match): cpu_resp_valid=1 next cycle with the word.
//    FSM stays IDLE. Throughput is one hit per cycle.
//  IDLE, request accepted, miss: latch addr; go to REFILL_REQ.
//  REFILL_REQ: mem_req_valid=1, mem_req_addr held stable until mem_req_ready. Then go to REFILL_DATA.
//  REFILL_DATA: each mem_resp_valid writes data[idx][beat], then beat++.
//    On beat LINE_WORDS-1: write tag, set valid[idx], go to RESPOND.
//  RESPOND: cpu_resp_valid=1 with the requested word from the refilled line; next state IDLE.
//  Miss latency from accept: 1 + req-handshake wait + LINE_WORDS beats + 1 cycles.
//  Eviction: a miss overwrites the line at idx unconditionally. No write-back; the cache is read-only.
//  mem_resp_valid outside REFILL_DATA is ignored.
//  cpu_resp_data holds its last value when cpu_resp_valid=0.
//  Flush in IDLE: all valid bits clear at the next edge. A same-cycle request is not accepted.
//  Flush in any other state: set flush_pending. The refill completes and RESPOND still delivers the word.
//    In the first IDLE cycle, clear all valid bits and flush_pending.
//  Reset mid-refill: FSM returns to IDLE and the partial line stays invalid.
//    Any remaining memory beats are dropped.
//  Simultaneous rst and flush: rst wins.
// CONFIGURATION
//  ICACHE_PERF_CNT_EN defined: adds outputs hit_count and miss_count, 32 bits each.
//    Each increments by 1 per accepted hit or miss and wraps at 2^32.
//    Cleared by rst only, not by flush.
//  ICACHE_PERF_CNT_EN undefined: these ports and counters do not exist. Functional behaviour is identical.
// TESTING (defaults: 16B line, idx=[7:4])
//  1. After rst, read 0x100 -> mem_req_addr=0x100. Send beats A0..A3.
//     -> cpu_resp_valid 1 cycle after the last beat with data A0. (PERF: miss_count=1.)
//  2. Then reads 0x104, 0x108, 0x10C on consecutive cycles.
//     -> resp A1, A2, A3 on 3 consecutive cycles; mem_req_valid stays 0.
//  3. Read 0x500 (same idx 0, different tag) -> refill B0..B3, resp B0.
//     Then read 0x100 -> miss again, mem_req_addr=0x100.
//  4. Assert flush during REFILL_DATA of 0x200 -> resp still returns the 0x200 word.
//     The next read of 0x200 misses; cpu_req_ready=0 during the pending-flush IDLE cycle.
//  5. Assert rst after 2 of 4 beats -> all outputs 0 next cycle. The next 2 beats are ignored.
//     A later read of the same addr misses.
//  6. Hold mem_req_ready=0 for 5 cycles -> mem_req_valid and mem_req_addr stay stable.
//     cpu_req_ready=0 throughout.

Source files
------------

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with multi-word lines and a refill FSM.
// Optional hit/miss counters when ICACHE_PERF_CNT_EN is defined.
module icache_dm #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_valid,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    output logic              cpu_req_ready,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_data,
    input  logic              flush,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);

    localparam int OFF_B   = $clog2(DATA_W / 8);
    localparam int WRD_B   = $clog2(LINE_WORDS);
    localparam int IDX_B   = $clog2(SETS);
    localparam int WRD_BW  = (WRD_B > 0) ? WRD_B : 1;
    localparam int TAG_LSB = OFF_B + WRD_B + IDX_B;
    localparam int TAG_W   = ADDR_W - TAG_LSB;
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS * (DATA_W / 8) - 1);
    localparam logic [ADDR_W-1:0] WRD_MASK  = ADDR_W'(LINE_WORDS - 1);
    localparam logic [WRD_BW-1:0] LAST_BEAT = WRD_BW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REFILL_REQ,
        REFILL_DATA,
        RESPOND
    } state_t;

    state_t state, state_next;

    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  tags  [SETS];
    logic [DATA_W-1:0] lines [SETS][LINE_WORDS];

    logic [ADDR_W-1:0] miss_addr;
    logic [WRD_BW-1:0] beat;
    logic              flush_pending;

    logic [IDX_B-1:0]  req_idx, miss_idx;
    logic [TAG_W-1:0]  req_tag, miss_tag;
    logic [WRD_BW-1:0] req_wrd, miss_wrd;
    logic              accept, hit, beat_fire, last_beat;

    assign req_idx  = cpu_req_addr[OFF_B+WRD_B +: IDX_B];
    assign req_tag  = cpu_req_addr[ADDR_W-1:TAG_LSB];
    assign req_wrd  = WRD_BW'((cpu_req_addr >> OFF_B) & WRD_MASK);
    assign miss_idx = miss_addr[OFF_B+WRD_B +: IDX_B];
    assign miss_tag = miss_addr[ADDR_W-1:TAG_LSB];
    assign miss_wrd = WRD_BW'((miss_addr >> OFF_B) & WRD_MASK);

    assign cpu_req_ready = (state == IDLE) && !flush && !flush_pending;
    assign accept        = cpu_req_valid && cpu_req_ready;
    assign hit           = valid[req_idx] && (tags[req_idx] == req_tag);
    assign beat_fire     = (state == REFILL_DATA) && mem_resp_valid;
    assign last_beat     = beat_fire && (beat == LAST_BEAT);

    assign mem_req_valid = (state == REFILL_REQ);
    assign mem_req_addr  = (state == REFILL_REQ) ? (miss_addr & ~LINE_MASK) : '0;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:        if (accept && !hit) state_next = REFILL_REQ;
            REFILL_REQ:  if (mem_req_ready) state_next = REFILL_DATA;
            REFILL_DATA: if (last_beat) state_next = RESPOND;
            RESPOND:     state_next = IDLE;
            default:     state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid          <= '0;
            flush_pending  <= 1'b0;
            beat           <= '0;
            miss_addr      <= '0;
            cpu_resp_valid <= 1'b0;
            cpu_resp_data  <= '0;
        end else begin
            cpu_resp_valid <= 1'b0;
            if (accept && hit) begin
                cpu_resp_valid <= 1'b1;
                cpu_resp_data  <= lines[req_idx][req_wrd];
            end
            if (accept && !hit) miss_addr <= cpu_req_addr;
            if (beat_fire) beat <= last_beat ? '0 : beat + 1'b1;
            // The final beat is forwarded directly since its array write lands at this edge.
            if (last_beat) begin
                valid[miss_idx] <= 1'b1;
                cpu_resp_valid  <= 1'b1;
                cpu_resp_data   <= (miss_wrd == beat) ? mem_resp_data
                                                      : lines[miss_idx][miss_wrd];
            end
            if (state == IDLE) begin
                if (flush || flush_pending) begin
                    valid         <= '0;
                    flush_pending <= 1'b0;
                end
            end else if (flush) begin
                flush_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && beat_fire) lines[miss_idx][beat] <= mem_resp_data;
        if (!rst && last_beat) tags[miss_idx] <= miss_tag;
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept) begin
            if (hit) hit_count  <= hit_count + 32'd1;
            else     miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios plus randomized
// traffic compared every cycle against a behavioural cache model.
module tb_icache_dm;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req_valid;
    logic [31:0] cpu_req_addr;
    logic        cpu_req_ready;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_data;
    logic        flush;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    icache_dm dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_data  (cpu_resp_data),
        .flush          (flush),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data)
`ifdef ICACHE_PERF_CNT_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return 32'hA000_0000 | (a & 32'h00FF_FFFC);
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timeout", nm);
    endtask

    // Behavioural model: cache contents as per-index valid/tag, data is memory.
    bit          model_on = 0;
    bit          mv [16];
    logic [31:0] mt [16];
    bit          busy, wait_req, fpend;
    int          left;
    logic [31:0] maddr;
    bit          ev;
    logic [31:0] ed;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            model_on = 1;
            foreach (mv[i]) mv[i] = 0;
            busy = 0; wait_req = 0; fpend = 0; left = 0;
            ev = 0; ed = '0; maddr = '0;
        end else if (model_on) begin
            ev = 0;
            if (!busy) begin
                if (flush || fpend) begin
                    foreach (mv[i]) mv[i] = 0;
                    fpend = 0;
                end else if (cpu_req_valid) begin
                    int ix;
                    ix = int'((cpu_req_addr >> 4) % 16);
                    if (mv[ix] && mt[ix] == (cpu_req_addr >> 8)) begin
                        ev = 1;
                        ed = memw(cpu_req_addr);
                    end else begin
                        busy = 1; wait_req = 1; left = LW; maddr = cpu_req_addr;
                    end
                end
            end else begin
                if (flush) fpend = 1;
                if (wait_req) begin
                    if (mem_req_ready) wait_req = 0;
                end else if (left > 0) begin
                    if (mem_resp_valid) begin
                        left--;
                        if (left == 0) begin
                            int ix;
                            ix = int'((maddr >> 4) % 16);
                            mv[ix] = 1;
                            mt[ix] = maddr >> 8;
                            ev = 1;
                            ed = memw(maddr);
                        end
                    end
                end else begin
                    busy = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        #1;
        if (model_on) begin
            chk("cpu_req_ready", {31'd0, cpu_req_ready}, {31'd0, !busy && !flush && !fpend});
            chk("cpu_resp_valid", {31'd0, cpu_resp_valid}, {31'd0, ev});
            chk("cpu_resp_data", cpu_resp_data, ed);
            chk("mem_req_valid", {31'd0, mem_req_valid}, {31'd0, busy && wait_req});
            if (busy && wait_req) chk("mem_req_addr", mem_req_addr, maddr & ~32'hF);
        end
    end

    // Memory responder: 0 = ready low, 1 = ready high, 2 = random.
    int          ready_mode = 1;
    int          beat_mode = 1;
    int          rleft = 0;
    int          beats_sent = 0;
    logic [31:0] rline = '0;
    bit          hs_flag = 0, beat_flag = 0;
    logic [31:0] hs_addr = '0;

    initial begin
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            if (hs_flag) begin
                rline = hs_addr; rleft = LW; beats_sent = 0;
            end else if (beat_flag && rleft > 0) begin
                rleft--; beats_sent++;
            end
            mem_req_ready = (ready_mode == 1) ? 1'b1 :
                            (ready_mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            mem_resp_valid = (rleft > 0) &&
                             ((beat_mode == 1) || ($urandom_range(0, 9) < 6));
            mem_resp_data = memw(rline + 32'(4 * (LW - rleft)));
            #1;
            hs_flag   = mem_req_valid && mem_req_ready;
            hs_addr   = mem_req_addr;
            beat_flag = mem_resp_valid;
        end
    end

    task automatic fetch(input logic [31:0] a);
        bit ok;
        ok = 0;
        @(negedge clk);
        cpu_req_valid = 1'b1;
        cpu_req_addr  = a;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (cpu_req_ready) begin
                ok = 1;
                @(posedge clk);
                #1;
                break;
            end
            @(negedge clk);
        end
        cpu_req_valid = 1'b0;
        if (!ok) timeout("fetch");
    endtask

    task automatic wait_mem_req();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (mem_req_valid) begin ok = 1; break; end
        end
        if (!ok) timeout("wait_mem_req");
    endtask

    task automatic wait_resp();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (cpu_resp_valid) begin ok = 1; break; end
        end
        if (!ok) timeout("wait_resp");
    endtask

    task automatic wait_beats(input int n);
        bit ok;
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #2;
            if (beats_sent >= n) begin ok = 1; break; end
        end
        if (!ok) timeout("wait_beats");
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        cpu_req_valid = 1'b0; cpu_req_addr = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
        chk("rst_resp_data", cpu_resp_data, 32'd0);
        chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("rst_mem_req_addr", mem_req_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        fetch(32'h100);
        wait_mem_req();
        chk("t1_req_addr", mem_req_addr, 32'h100);
        wait_resp();
        chk("t1_data", cpu_resp_data, 32'hA000_0100);

        @(negedge clk);
        cpu_req_valid = 1'b1; cpu_req_addr = 32'h104;
        @(negedge clk);
        cpu_req_addr = 32'h108;
        #1;
        chk("t2_v1", {31'd0, cpu_resp_valid}, 32'd1);
        chk("t2_d1", cpu_resp_data, 32'hA000_0104);
        @(negedge clk);
        cpu_req_addr = 32'h10C;
        #1;
        chk("t2_d2", cpu_resp_data, 32'hA000_0108);
        chk("t2_memreq", {31'd0, mem_req_valid}, 32'd0);
        @(negedge clk);
        cpu_req_valid = 1'b0;
        #1;
        chk("t2_v3", {31'd0, cpu_resp_valid}, 32'd1);
        chk("t2_d3", cpu_resp_data, 32'hA000_010C);
        chk("t2_memreq3", {31'd0, mem_req_valid}, 32'd0);

        fetch(32'h500);
        wait_mem_req();
        chk("t3_req_addr", mem_req_addr, 32'h500);
        wait_resp();
        chk("t3_data", cpu_resp_data, 32'hA000_0500);
        fetch(32'h100);
        wait_mem_req();
        chk("t3_remiss_addr", mem_req_addr, 32'h100);
        wait_resp();

        fetch(32'h208);
        wait_mem_req();
        wait_beats(1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_resp();
        chk("t4_data", cpu_resp_data, 32'hA000_0208);
        @(negedge clk);
        #1;
        chk("t4_ready_pending", {31'd0, cpu_req_ready}, 32'd0);
        fetch(32'h208);
        wait_mem_req();
        chk("t4_remiss_addr", mem_req_addr, 32'h200);
        wait_resp();

        fetch(32'h304);
        wait_mem_req();
        wait_beats(2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t5_resp_valid", {31'd0, cpu_resp_valid}, 32'd0);
        chk("t5_resp_data", cpu_resp_data, 32'd0);
        chk("t5_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        chk("t5_mem_req_addr", mem_req_addr, 32'd0);
        fetch(32'h304);
        wait_mem_req();
        chk("t5_remiss_addr", mem_req_addr, 32'h300);
        wait_resp();
        chk("t5_data", cpu_resp_data, 32'hA000_0304);

        ready_mode = 0;
        fetch(32'h60C);
        wait_mem_req();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("t6_valid", {31'd0, mem_req_valid}, 32'd1);
            chk("t6_addr", mem_req_addr, 32'h600);
            chk("t6_ready", {31'd0, cpu_req_ready}, 32'd0);
        end
        ready_mode = 1;
        wait_resp();
        chk("t6_data", cpu_resp_data, 32'hA000_060C);

        ready_mode = 2;
        beat_mode  = 2;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst           = ($urandom_range(0, 399) == 0);
            flush         = ($urandom_range(0, 49) == 0);
            cpu_req_valid = ($urandom_range(0, 9) < 7);
            cpu_req_addr  = (32'($urandom_range(0, 3)) << 8) | 32'($urandom_range(0, 255));
        end
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; cpu_req_valid = 1'b0;
        repeat (20) @(negedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
